traffic_light_nway: RTL and testbench

//  Parametrised N-direction traffic-light controller: successor to the 2-road, 4-state

---
 rtl/traffic_pkg.sv | 30 +++
 rtl/traffic_rr_pick.sv | 39 +++
 rtl/traffic_light_nway.sv | 149 ++++++++++++++
 tb/tb_traffic_light_nway.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared lamp codes and phase encoding for the N-way traffic
//               light controller, its lamp decoder and its testbench.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    // Lamp codes, two bits per direction on the lights bus
    localparam logic [1:0] LAMP_GREEN  = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_RED    = 2'b11;

    // Phase encoding of the controller FSM
    localparam logic [1:0] PH_GREEN    = 2'd0;
    localparam logic [1:0] PH_YELLOW   = 2'd1;
    localparam logic [1:0] PH_ALLRED   = 2'd2;

    // Lamp shown by the direction that owns the current phase
    function automatic logic [1:0] owner_lamp(input logic [1:0] phase);
        case (phase)
            PH_GREEN:  owner_lamp = LAMP_GREEN;
            PH_YELLOW: owner_lamp = LAMP_YELLOW;
            default:   owner_lamp = LAMP_RED;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : traffic_rr_pick
// Description : Combinational round-robin picker. Returns the first requesting
//               direction after cur (wrapping), never cur itself.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_rr_pick #(
    parameter int N_DIR = 4
) (
    input  logic [N_DIR-1:0]         req,
    input  logic [$clog2(N_DIR)-1:0] cur,
    output logic                     valid,
    output logic [$clog2(N_DIR)-1:0] idx
);

    localparam int IDX_W = $clog2(N_DIR);
    localparam logic [IDX_W:0] c_N_DIR = (IDX_W+1)'(N_DIR);

    // Scan offsets from farthest to nearest so the nearest requester wins
    always_comb begin
        logic [IDX_W:0] v_sum;
        v_sum = '0;
        valid = 1'b0;
        idx   = cur;
        for (int j = N_DIR - 1; j >= 1; j--) begin
            v_sum = {1'b0, cur} + (IDX_W+1)'(j);
            if (v_sum >= c_N_DIR) begin
                v_sum = v_sum - c_N_DIR;
            end
            if (req[v_sum[IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = v_sum[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/traffic_light_nway.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_nway
// Description : N-direction sensor-driven round-robin traffic light
//               controller with min/max green, yellow and all-red timers and
//               a parade-mode latch that pins green on HOLD_DIR.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_nway
    import traffic_pkg::*;
#(
    parameter int N_DIR      = 4,
    parameter int TIMER_W    = 8,
    parameter int GREEN_MIN  = 4,
    parameter int GREEN_MAX  = 10,
    parameter int YELLOW_CYC = 2,
    parameter int ALLRED_CYC = 1,
    parameter int HOLD_DIR   = N_DIR - 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_DIR-1:0]         traffic,
    input  logic                     p,
    input  logic                     r,
    output logic [2*N_DIR-1:0]       lights,
    output logic [$clog2(N_DIR)-1:0] cur_dir,
    output logic                     mode
);

    localparam int IDX_W = $clog2(N_DIR);
    localparam logic [TIMER_W-1:0] c_GREEN_MIN_T = TIMER_W'(GREEN_MIN - 1);
    localparam logic [TIMER_W-1:0] c_GREEN_MAX_T = TIMER_W'(GREEN_MAX - 1);
    localparam logic [TIMER_W-1:0] c_YELLOW_T    = TIMER_W'(YELLOW_CYC - 1);
    localparam logic [TIMER_W-1:0] c_ALLRED_T    = TIMER_W'(ALLRED_CYC - 1);
    localparam logic [IDX_W-1:0]   c_HOLD        = IDX_W'(HOLD_DIR);

    logic [1:0]         r_phase;
    logic [TIMER_W-1:0] r_timer;
    logic [IDX_W-1:0]   r_cur;
    logic [IDX_W-1:0]   r_next;
    logic               r_mode;

    logic               w_pick_valid;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_green_exit;
    logic [IDX_W-1:0]   w_green_next;
    logic [TIMER_W-1:0] w_timer_inc;
    logic [2*N_DIR-1:0] w_lights;

    traffic_rr_pick #(
        .N_DIR (N_DIR)
    ) u_rr_pick (
        .req   (traffic),
        .cur   (r_cur),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    // Saturating phase timer increment
    assign w_timer_inc = (r_timer == '1) ? r_timer : r_timer + 1'b1;

    // Decide whether the green phase ends this cycle and who goes next;
    // green only ends when there is somewhere useful to go
    always_comb begin
        w_green_exit = 1'b0;
        w_green_next = w_pick_idx;
        if (r_timer >= c_GREEN_MIN_T) begin
            if (r_mode) begin
                if (r_cur != c_HOLD) begin
                    w_green_exit = 1'b1;
                    w_green_next = c_HOLD;
                end
            end else if (w_pick_valid &&
                         (!traffic[r_cur] || (r_timer >= c_GREEN_MAX_T))) begin
                w_green_exit = 1'b1;
            end
        end
    end

    // Parade-mode latch: clear has priority over set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= 1'b0;
        end else if (r) begin
            r_mode <= 1'b0;
        end else if (p) begin
            r_mode <= 1'b1;
        end
    end

    // Phase FSM; next direction is frozen at the green exit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= PH_GREEN;
            r_timer <= '0;
            r_cur   <= '0;
            r_next  <= '0;
        end else begin
            case (r_phase)
                PH_GREEN: begin
                    if (w_green_exit) begin
                        r_phase <= PH_YELLOW;
                        r_timer <= '0;
                        r_next  <= w_green_next;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                PH_YELLOW: begin
                    if (r_timer >= c_YELLOW_T) begin
                        r_phase <= PH_ALLRED;
                        r_timer <= '0;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                PH_ALLRED: begin
                    if (r_timer >= c_ALLRED_T) begin
                        r_phase <= PH_GREEN;
                        r_timer <= '0;
                        r_cur   <= r_next;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                default: begin
                    r_phase <= PH_GREEN;
                    r_timer <= '0;
                end
            endcase
        end
    end

    // Lamp decoder: owner shows the phase lamp, everyone else stays red
    always_comb begin
        w_lights = '1;
        for (int k = 0; k < N_DIR; k++) begin
            if (r_cur == IDX_W'(k)) begin
                w_lights[2*k +: 2] = owner_lamp(r_phase);
            end
        end
    end

    assign lights  = w_lights;
    assign cur_dir = r_cur;
    assign mode    = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_nway.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_light_nway
// Description : Self-checking bench for traffic_light_nway with directed
//               scenarios and a randomized run against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_nway;
    import traffic_pkg::*;

    localparam int N    = 4;
    localparam int GMIN = 4;
    localparam int GMAX = 10;
    localparam int YC   = 2;
    localparam int AC   = 1;
    localparam int HOLD = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] traffic = 4'b0000;
    logic       p = 1'b0;
    logic       r = 1'b0;
    logic [7:0] lights;
    logic [1:0] cur_dir;
    logic       mode;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    traffic_light_nway #(
        .N_DIR      (N),
        .TIMER_W    (8),
        .GREEN_MIN  (GMIN),
        .GREEN_MAX  (GMAX),
        .YELLOW_CYC (YC),
        .ALLRED_CYC (AC),
        .HOLD_DIR   (HOLD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .traffic (traffic),
        .p       (p),
        .r       (r),
        .lights  (lights),
        .cur_dir (cur_dir),
        .mode    (mode)
    );

    // ---------------- behavioural model ----------------
    typedef enum int {M_GREEN, M_YELLOW, M_ALLRED} mphase_t;
    mphase_t m_ph   = M_GREEN;
    int      m_age  = 0;   // cycles spent in current phase, unbounded
    int      m_cur  = 0;
    int      m_next = 0;
    bit      m_mode = 1'b0;

    function automatic int rr_pick(input logic [3:0] t, input int c);
        for (int o = 1; o < N; o++) begin
            if (((t >> ((c + o) % N)) & 4'b0001) != 4'b0000) return (c + o) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input bit rs, input logic [3:0] t, input bit pp, input bit rq);
        int  pick;
        bit  own_busy;
        if (rs) begin
            m_ph = M_GREEN; m_age = 0; m_cur = 0; m_next = 0; m_mode = 1'b0;
        end else begin
            case (m_ph)
                M_GREEN: begin
                    pick     = rr_pick(t, m_cur);
                    own_busy = ((t >> m_cur) & 4'b0001) != 4'b0000;
                    if (m_age >= GMIN - 1 && m_mode && m_cur != HOLD) begin
                        m_ph = M_YELLOW; m_age = 0; m_next = HOLD;
                    end else if (m_age >= GMIN - 1 && !m_mode && pick >= 0 &&
                                 (!own_busy || m_age >= GMAX - 1)) begin
                        m_ph = M_YELLOW; m_age = 0; m_next = pick;
                    end else begin
                        m_age++;
                    end
                end
                M_YELLOW: begin
                    if (m_age >= YC - 1) begin m_ph = M_ALLRED; m_age = 0; end
                    else m_age++;
                end
                default: begin
                    if (m_age >= AC - 1) begin m_ph = M_GREEN; m_age = 0; m_cur = m_next; end
                    else m_age++;
                end
            endcase
            if (rq) m_mode = 1'b0;
            else if (pp) m_mode = 1'b1;
        end
    endtask

    function automatic logic [7:0] m_lights();
        logic [1:0] code;
        if (m_ph == M_ALLRED) return 8'hFF;
        code = (m_ph == M_GREEN) ? LAMP_GREEN : LAMP_YELLOW;
        return (8'hFF & ~(8'h03 << (2 * m_cur))) | (8'(code) << (2 * m_cur));
    endfunction

    // Drive one cycle of inputs, let the DUT and the model both take the edge
    task automatic tick(input bit rs, input logic [3:0] t, input bit pp, input bit rq);
        rst = rs; traffic = t; p = pp; r = rq;
        @(posedge clk);
        model_step(rs, t, pp, rq);
        #1;
    endtask

    // ---------------- safety monitor ----------------
    logic [7:0] prev_l = 8'hFF;
    bit         last_rst = 1'b1;
    always @(posedge clk) last_rst <= rst;

    // At most one lit lamp; a lamp turning green must follow an all-red cycle
    always @(negedge clk) begin
        int lit;
        lit = 0;
        for (int k = 0; k < N; k++) if (((lights >> (2 * k)) & 8'h03) != 8'h03) lit++;
        total++;
        if (lit > 1) begin
            bad++;
            $display("FAIL one_lamp: lights=%b lit=%0d required<=1", lights, lit);
        end
        for (int k = 0; k < N; k++) begin
            if (((lights >> (2 * k)) & 8'h03) == 8'h00 &&
                ((prev_l >> (2 * k)) & 8'h03) != 8'h00 && !last_rst) begin
                total++;
                if (prev_l !== 8'hFF) begin
                    bad++;
                    $display("FAIL green_after_allred: dir%0d prev=%b required=11111111", k, prev_l);
                end
            end
        end
        prev_l = lights;
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int i = 0; i < 50; i++) begin
            tick(1'b1, 4'b0000, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            total++;
            if (lights !== 8'hFC) begin bad++; $display("FAIL reset_lights: got=%b exp=11111100", lights); end
            total++;
            if (cur_dir !== 2'd0) begin bad++; $display("FAIL reset_cur: got=%0d exp=0", cur_dir); end
            total++;
            if (mode !== 1'b0) begin bad++; $display("FAIL reset_mode: got=%b exp=0", mode); end
        end
    endtask

    task automatic test_min_release();
        logic [7:0] exp_l [8];
        exp_l = '{8'hFC, 8'hFC, 8'hFC, 8'hFC, 8'hFD, 8'hFD, 8'hFF, 8'hCF};
        rst = 1'b0; traffic = 4'b0100;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick(1'b0, 4'b0100, 1'b0, 1'b0);
            total++;
            if (lights !== exp_l[c]) begin
                bad++; $display("FAIL min_release cyc%0d: got=%b exp=%b", c, lights, exp_l[c]);
            end
        end
        total++;
        if (cur_dir !== 2'd2) begin bad++; $display("FAIL min_release_cur: got=%0d exp=2", cur_dir); end
    endtask

    task automatic test_max_green();
        logic [7:0] exp;
        tick(1'b1, 4'b0011, 1'b0, 1'b0);
        for (int c = 0; c < 14; c++) begin
            if (c > 0) tick(1'b0, 4'b0011, 1'b0, 1'b0);
            exp = (c < 10) ? 8'hFC : (c < 12) ? 8'hFD : (c == 12) ? 8'hFF : 8'hF3;
            total++;
            if (lights !== exp) begin
                bad++; $display("FAIL max_green cyc%0d: got=%b exp=%b", c, lights, exp);
            end
        end
        total++;
        if (cur_dir !== 2'd1) begin bad++; $display("FAIL max_green_next: got=%0d exp=1", cur_dir); end
    endtask

    task automatic test_parade();
        logic [7:0] seq_l [6];
        tick(1'b0, 4'b0110, 1'b1, 1'b0);
        total++;
        if (mode !== 1'b1) begin bad++; $display("FAIL parade_set: mode=%b exp=1", mode); end
        seq_l = '{8'hF3, 8'hF3, 8'hF7, 8'hF7, 8'hFF, 8'h3F};
        for (int c = 0; c < 6; c++) begin
            tick(1'b0, 4'b0110, 1'b0, 1'b0);
            total++;
            if (lights !== seq_l[c]) begin
                bad++; $display("FAIL parade_leave step%0d: got=%b exp=%b", c, lights, seq_l[c]);
            end
        end
        for (int c = 0; c < 35; c++) begin
            tick(1'b0, 4'b1111, 1'b0, 1'b0);
            total++;
            if (lights !== 8'h3F || cur_dir !== 2'd3) begin
                bad++; $display("FAIL parade_hold cyc%0d: lights=%b cur=%0d exp=00111111/3", c, lights, cur_dir);
            end
        end
        tick(1'b0, 4'b1111, 1'b0, 1'b1);
        total++;
        if (mode !== 1'b0 || lights !== 8'h3F) begin
            bad++; $display("FAIL parade_clear: mode=%b lights=%b exp=0/00111111", mode, lights);
        end
        seq_l = '{8'h7F, 8'h7F, 8'hFF, 8'hFC, 8'hFC, 8'hFC};
        for (int c = 0; c < 4; c++) begin
            tick(1'b0, 4'b1111, 1'b0, 1'b0);
            total++;
            if (lights !== seq_l[c]) begin
                bad++; $display("FAIL parade_release step%0d: got=%b exp=%b", c, lights, seq_l[c]);
            end
        end
        total++;
        if (cur_dir !== 2'd0) begin bad++; $display("FAIL parade_release_cur: got=%0d exp=0", cur_dir); end
    endtask

    task automatic test_pr_same();
        bit exp_m [4];
        bit pv [4];
        bit rv [4];
        exp_m = '{1'b0, 1'b0, 1'b1, 1'b0};
        pv    = '{1'b1, 1'b0, 1'b1, 1'b0};
        rv    = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int c = 0; c < 4; c++) begin
            tick(1'b0, 4'b0000, pv[c], rv[c]);
            total++;
            if (mode !== exp_m[c]) begin
                bad++; $display("FAIL pr_latch step%0d: mode=%b exp=%b", c, mode, exp_m[c]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int  n;
        tick(1'b1, 4'b0100, 1'b0, 1'b0);
        tick(1'b0, 4'b0100, 1'b1, 1'b0);
        n = 0;
        while (!(m_ph == M_YELLOW && m_age == 0) && n < 20) begin
            tick(1'b0, 4'b0100, 1'b0, 1'b0);
            n++;
        end
        total++;
        if (lights !== 8'hFD || mode !== 1'b1) begin
            bad++; $display("FAIL reset_mid_setup: lights=%b mode=%b exp=11111101/1 waited=%0d", lights, mode, n);
        end
        tick(1'b1, 4'b0100, 1'b0, 1'b0);
        total++;
        if (lights !== 8'hFC || cur_dir !== 2'd0 || mode !== 1'b0) begin
            bad++; $display("FAIL reset_mid: lights=%b cur=%0d mode=%b exp=11111100/0/0", lights, cur_dir, mode);
        end
        // Timer restarted: exactly GREEN_MIN green cycles before yellow
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick(1'b0, 4'b0100, 1'b0, 1'b0);
            total++;
            if (lights !== ((c < 4) ? 8'hFC : 8'hFD)) begin
                bad++; $display("FAIL reset_mid_timer cyc%0d: got=%b exp=%b", c, lights, (c < 4) ? 8'hFC : 8'hFD);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] t;
        bit rs, pp, rq;
        t = 4'($urandom);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) t = 4'($urandom);
            rs = ($urandom_range(0, 199) == 0);
            pp = ($urandom_range(0, 24) == 0);
            rq = ($urandom_range(0, 29) == 0);
            tick(rs, t, pp, rq);
            total++;
            if (lights !== m_lights() || cur_dir !== 2'(m_cur) || mode !== m_mode) begin
                bad++;
                $display("FAIL random cyc%0d: lights=%b cur=%0d mode=%b exp=%b/%0d/%b",
                         i, lights, cur_dir, mode, m_lights(), m_cur, m_mode);
            end
        end
    endtask

    initial begin
        test_reset();
        test_min_release();
        test_max_green();
        test_parade();
        test_pr_same();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
